// File: rtl/pong_pkg.sv
// Shared types and default sizes for the paddle engine.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2
    } motion_state_t;

    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_SIZE_W   = 8;

endpackage

// File: rtl/paddle_motion.sv
// One paddle: direction FSM plus frame-synchronous y register with clamping.
// Optional ramped speed when PADDLE_ACCEL_EN is defined.
module paddle_motion
    import pong_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int SIZE_W    = DEF_SIZE_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int INIT_Y    = 200,
    parameter int MAX_SPEED = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic [SIZE_W-1:0]  height,
    output logic [COORD_W-1:0] y,
    output logic               at_top,
    output logic               at_bottom
);

    localparam int EXT_W = COORD_W + 1;

    motion_state_t        state;
    motion_state_t        state_next;
    logic [COORD_W-1:0]   speed_next;
    logic [EXT_W-1:0]     y_ext;
    logic [EXT_W-1:0]     limit;
    logic [EXT_W-1:0]     cand;
    logic [EXT_W-1:0]     y_next_ext;

    assign y_ext = {1'b0, y};
    assign limit = EXT_W'(SCREEN_H) - EXT_W'(height);

    always_comb begin
        state_next = IDLE;
        if (up && !down) begin
            state_next = MOVE_UP;
        end else if (down && !up) begin
            state_next = MOVE_DN;
        end
    end

`ifdef PADDLE_ACCEL_EN
    logic [COORD_W-1:0] speed;

    // Speed restarts at 1 whenever the direction changes or motion starts.
    always_comb begin
        speed_next = '0;
        if (state_next != IDLE) begin
            if (state_next != state) begin
                speed_next = COORD_W'(1);
            end else if (speed < COORD_W'(MAX_SPEED)) begin
                speed_next = speed + COORD_W'(1);
            end else begin
                speed_next = COORD_W'(MAX_SPEED);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed <= '0;
        end else if (frame_tick) begin
            speed <= speed_next;
        end
    end
`else
    assign speed_next = (state_next == IDLE) ? '0 : COORD_W'(MAX_SPEED);
`endif

    // The final clamp also pulls y back when the height grows past the limit.
    always_comb begin
        cand = y_ext;
        case (state_next)
            MOVE_UP: cand = (y_ext < EXT_W'(speed_next)) ? '0 : (y_ext - EXT_W'(speed_next));
            MOVE_DN: cand = y_ext + EXT_W'(speed_next);
            default: cand = y_ext;
        endcase
        y_next_ext = (cand > limit) ? limit : cand;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            y     <= COORD_W'(INIT_Y);
        end else if (frame_tick) begin
            state <= state_next;
            y     <= COORD_W'(y_next_ext);
        end
    end

    assign at_top    = (y == '0);
    assign at_bottom = (y_ext == limit);

endmodule

// File: rtl/paddle_engine.sv
// Multi-paddle engine: per-paddle motion, rounded-corner hit test, registered pixel output.
// Build option: define PADDLE_ACCEL_EN for ramped paddle speed.
module paddle_engine
    import pong_pkg::*;
#(
    parameter int N_PADDLES   = 2,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SIZE_W      = DEF_SIZE_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int INIT_Y      = 200,
    parameter int MAX_SPEED   = 8,
    parameter int CORNER      = 3,
    localparam int ID_W       = (N_PADDLES > 1) ? $clog2(N_PADDLES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic [N_PADDLES-1:0]           up,
    input  logic [N_PADDLES-1:0]           down,
    input  logic [N_PADDLES*COORD_W-1:0]   x_paddle,
    input  logic [SIZE_W-1:0]              height_paddle,
    input  logic [SIZE_W-1:0]              width_paddle,
    input  logic [COORD_W-1:0]             xpix,
    input  logic [COORD_W-1:0]             ypix,
    output logic [N_PADDLES*COORD_W-1:0]   y_paddle,
    output logic                           pixval,
    output logic [ID_W-1:0]                pix_id,
    output logic [N_PADDLES-1:0]           at_top,
    output logic [N_PADDLES-1:0]           at_bottom
);

    localparam int EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0] ONE = EXT_W'(1);

    logic [EXT_W-1:0]     xp;
    logic [EXT_W-1:0]     yp;
    logic [EXT_W-1:0]     w_ext;
    logic [EXT_W-1:0]     h_ext;
    logic [EXT_W-1:0]     c_ext;
    logic [N_PADDLES-1:0] hit;
    logic [ID_W-1:0]      hit_id;

    assign xp    = {1'b0, xpix};
    assign yp    = {1'b0, ypix};
    assign w_ext = EXT_W'(width_paddle);
    assign h_ext = EXT_W'(height_paddle);
    assign c_ext = EXT_W'(CORNER);

    for (genvar i = 0; i < N_PADDLES; i++) begin : g_paddle
        logic [EXT_W-1:0] x0;
        logic [EXT_W-1:0] y0;
        logic [EXT_W-1:0] x_end;
        logic [EXT_W-1:0] y_end;
        logic             body;
        logic             cap_col;
        logic             cap_top;
        logic             cap_bot;

        paddle_motion #(
            .COORD_W   (COORD_W),
            .SIZE_W    (SIZE_W),
            .SCREEN_H  (SCREEN_H),
            .INIT_Y    (INIT_Y),
            .MAX_SPEED (MAX_SPEED)
        ) u_motion (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .up         (up[i]),
            .down       (down[i]),
            .height     (height_paddle),
            .y          (y_paddle[i*COORD_W +: COORD_W]),
            .at_top     (at_top[i]),
            .at_bottom  (at_bottom[i])
        );

        assign x0    = {1'b0, x_paddle[i*COORD_W +: COORD_W]};
        assign y0    = {1'b0, y_paddle[i*COORD_W +: COORD_W]};
        assign x_end = x0 + w_ext;
        assign y_end = y0 + h_ext;

        // Corner rows are narrowed to the inner columns to give a rounded outline.
        assign body    = (x0 < xp) && (xp < x_end) && ((y0 + c_ext) < yp) && (yp < (y_end - c_ext));
        assign cap_col = ((x0 + c_ext - ONE) < xp) && (xp < (x_end - c_ext + ONE));
        assign cap_top = (y0 < yp) && (yp <= (y0 + c_ext));
        assign cap_bot = ((y_end - c_ext) <= yp) && (yp < y_end);
        assign hit[i]  = body || (cap_col && (cap_top || cap_bot));
    end

    always_comb begin
        hit_id = '0;
        for (int i = N_PADDLES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixval <= 1'b0;
            pix_id <= '0;
        end else begin
            pixval <= |hit;
            pix_id <= hit_id;
        end
    end

endmodule

// File: tb/tb_paddle_engine.sv
// Directed self-checking bench for paddle_engine (either PADDLE_ACCEL_EN build).
module tb_paddle_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [1:0]  up;
    logic [1:0]  down;
    logic [19:0] x_paddle;
    logic [7:0]  height_paddle;
    logic [7:0]  width_paddle;
    logic [9:0]  xpix;
    logic [9:0]  ypix;
    logic [19:0] y_paddle;
    logic        pixval;
    logic [0:0]  pix_id;
    logic [1:0]  at_top;
    logic [1:0]  at_bottom;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PADDLE_ACCEL_EN
    localparam int UP4[4] = '{199, 197, 194, 190};
    localparam int RST_UP = 199;
`else
    localparam int UP4[4] = '{192, 184, 176, 168};
    localparam int RST_UP = 192;
`endif

    paddle_engine dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .up            (up),
        .down          (down),
        .x_paddle      (x_paddle),
        .height_paddle (height_paddle),
        .width_paddle  (width_paddle),
        .xpix          (xpix),
        .ypix          (ypix),
        .y_paddle      (y_paddle),
        .pixval        (pixval),
        .pix_id        (pix_id),
        .at_top        (at_top),
        .at_bottom     (at_bottom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic ev, input int eid, input string tag);
        xpix = 10'(x);
        ypix = 10'(y);
        step();
        check({tag, "_val"}, 32'(pixval), 32'(ev));
        check({tag, "_id"}, 32'(pix_id), 32'(eid));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; up = 2'b00; down = 2'b00;
        x_paddle = {10'd300, 10'd20}; height_paddle = 8'd40; width_paddle = 8'd10;
        xpix = '0; ypix = '0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_y0", 32'(y_paddle[9:0]), 200);
        check("rst_y1", 32'(y_paddle[19:10]), 200);
        check("rst_pixval", 32'(pixval), 0);
        check("rst_pixid", 32'(pix_id), 0);
        check("rst_top", 32'(at_top), 0);
        check("rst_bot", 32'(at_bottom), 0);

        // Output is registered: no change before the clock edge.
        xpix = 10'd21; ypix = 10'd204; #1;
        check("lat_before", 32'(pixval), 0);
        step();
        check("lat_after", 32'(pixval), 1);
        pix(21, 201, 1'b0, 0, "cap_out_col");
        pix(25, 201, 1'b1, 0, "cap_top_in");
        pix(22, 202, 1'b0, 0, "cap_edge_col");
        pix(23, 202, 1'b1, 0, "cap_first_col");
        pix(27, 239, 1'b1, 0, "cap_bot_in");
        pix(28, 239, 1'b0, 0, "cap_bot_out");
        pix(20, 220, 1'b0, 0, "body_left");
        pix(29, 220, 1'b1, 0, "body_right");
        pix(30, 220, 1'b0, 0, "body_past");
        pix(301, 220, 1'b1, 1, "p1_hit");
        pix(0, 0, 1'b0, 0, "no_hit");
        x_paddle = {10'd20, 10'd20};
        pix(25, 220, 1'b1, 0, "overlap");
        x_paddle = {10'd300, 10'd20};

        up = 2'b01; down = 2'b01;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            check("both_req_y0", 32'(y_paddle[9:0]), 200);
        end
        down = 2'b00;
        repeat (3) step();
        check("midframe_y0", 32'(y_paddle[9:0]), 200);

        frame_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("up_held_y0", 32'(y_paddle[9:0]), 32'(UP4[i]));
        end
        reset = 1'b1;
        step();
        check("rst_tick_y0", 32'(y_paddle[9:0]), 200);
        reset = 1'b0;
        step();
        frame_tick = 1'b0;
        check("post_rst_y0", 32'(y_paddle[9:0]), 32'(RST_UP));

        frame_tick = 1'b1;
        repeat (40) step();
        check("top_y0", 32'(y_paddle[9:0]), 0);
        check("top_flag", 32'(at_top), 1);
        step();
        frame_tick = 1'b0;
        check("top_sat_y0", 32'(y_paddle[9:0]), 0);
        up = 2'b00;

        height_paddle = 8'd50; down = 2'b10;
        frame_tick = 1'b1;
        repeat (40) step();
        frame_tick = 1'b0;
        check("bot50_y1", 32'(y_paddle[19:10]), 430);
        check("bot50_flag", 32'(at_bottom), 2);
        height_paddle = 8'd40; #1;
        check("bot40_flag_pre", 32'(at_bottom), 0);
        frame_tick = 1'b1;
        step();
        check("bot_y1_a", 32'(y_paddle[19:10]), 438);
        step();
        check("bot_y1_b", 32'(y_paddle[19:10]), 440);
        check("bot40_flag", 32'(at_bottom), 2);
        step();
        frame_tick = 1'b0;
        check("bot_y1_sat", 32'(y_paddle[19:10]), 440);

        height_paddle = 8'd60; down = 2'b00; #1;
        check("grow_no_tick", 32'(y_paddle[19:10]), 440);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("grow_clamp_y1", 32'(y_paddle[19:10]), 420);
        check("grow_flag", 32'(at_bottom), 2);
        check("grow_y0", 32'(y_paddle[9:0]), 0);
        pix(305, 479, 1'b1, 1, "p1_bottom_cap");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
